led_display_pattern_gen_bcm: RTL and testbench
==============================================

Name: led_display_pattern_gen_bcm

Overview:
- Parametrised successor to the single-bit LED display pattern generator.
- Produces multi-bit colour test patterns as binary-coded-modulation (BCM) bit-planes for a HUB75-style panel of any size.
- Sits between the mode/colour control registers and the display driver PHY, feeding it one dual-row (top + bottom half) bit-plane per valid/ready transfer.
- Adds vertical scan and gradient modes and per-channel intensity depth.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency in Hz; informational, passed to the level sub-module.
- NUM_ROW_PIXELS, 32, physical panel rows; must be even. NUM_SCAN_ROWS = NUM_ROW_PIXELS/2.
- NUM_COL_PIXELS, 64, panel columns; power of two, >= 2**COLOUR_DEPTH.
- COLOUR_DEPTH, 4, intensity bits per channel (1..8); equals the number of bit-planes.
- SCAN_DIV, 4, frames per scan-position step.
- PULSE_DIV, 2, frames per pulse-level step.
- SIMULATION, 0, when 1 forces SCAN_DIV = PULSE_DIV = 1.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  asynchronous reset, active-high
- colour_in  in  3  channel enables: [0] red, [1] green, [2] blue
- mode_in  in  4  pattern mode (package enum)
- row_out  out  6*NUM_COL_PIXELS  {bot.blue, bot.green, bot.red, top.blue, top.green, top.red}; each field is NUM_COL_PIXELS wide, column 0 at the LSB.
- row_valid_out  out  1  row_out, row_address_out and plane_out are valid.
- row_ready_in  in  1  downstream accepts the row.
- row_address_out  out  $clog2(NUM_SCAN_ROWS)  scan-row address
- plane_out  out  max(1,$clog2(COLOUR_DEPTH))  bit-plane index; 0 is the LSB plane.
- frame_last_out  out  1  qualifies the final row of a frame (last address, last plane).

Behaviour:
- Reset: all outputs 0. Address, plane, frame counter, scan position and pulse level are 0; pulse direction is up.
- FSM states:
  - IDLE: entered on reset; moves to LOAD next cycle.
  - LOAD: registers the row for the current address/plane; moves to VALID.
  - VALID: row_valid_out=1; holds until row_ready_in.
- Registered output: first row_valid_out=1 on the 2nd rising edge after reset_in falls.
- Transfer occurs on valid && ready. Until then row_out, row_address_out, plane_out and frame_last_out stay stable.
- Throughput: with ready held high, one row per cycle. LOAD is skipped by a look-ahead register, so valid stays high continuously.
- Sequence: address increments fastest, 0..NUM_SCAN_ROWS-1. On wrap, plane increments, 0..COLOUR_DEPTH-1. On plane wrap the frame ends.
- Frame end:
  - Frame counter increments.
  - Scan position advances every SCAN_DIV frames.
  - Pulse level steps every PULSE_DIV frames.
- Mode or colour change, sampled every cycle against a registered copy:
  - Valid drops for exactly 1 cycle (forced LOAD).
  - Address, plane, frame counter, scan position and pulse level reset to 0; pulse direction resets to up.
  - The aborted row is never transferred.
  - A change coinciding with a transfer: the transfer completes, then the restart applies.
- Pixel bit: colour_in[ch] ? level[plane] : 0, where level is COLOUR_DEPTH bits and MAX = 2**COLOUR_DEPTH-1.
- Per-mode level (physical row = address for the top half, address + NUM_SCAN_ROWS for the bottom half):
  - MODE_OFF (0): all 0.
  - MODE_SOLID (1): MAX everywhere.
  - MODE_SCAN_H (2): MAX only at column == scan_pos; scan_pos wraps NUM_COL_PIXELS-1 -> 0.
  - MODE_SCAN_V (3): MAX only at physical row == scan_pos; scan_pos wraps NUM_ROW_PIXELS-1 -> 0.
  - MODE_PULSE (4): uniform triangle level 0 -> MAX -> 0. Reaching MAX reverses to down; reaching 0 reverses to up. Each endpoint is held for one step only.
  - MODE_GRADIENT (5): level = column[CW-1 -: COLOUR_DEPTH], where CW = $clog2(NUM_COL_PIXELS).
  - Undefined modes: treated as MODE_OFF.
- Reset asserted mid-transfer: outputs clear asynchronously; the sequence restarts from address 0, plane 0.

Optional Feature:
- Macro: LED_PATTERN_GAMMA_EN.
  - Defined: level passes through gamma-2 before bit-plane selection, level_out = (level*level) >> COLOUR_DEPTH, with MAX mapped to MAX. Adds one pipeline register, so first valid comes on the 3rd edge after reset. Handshake is otherwise unchanged.
  - Undefined: linear level, no extra stage.

Decomposition:
- led_display_package:
  - mode enum (MODE_OFF..MODE_GRADIENT), 4-bit.
  - Channel index constants RED = 0, GREEN = 1, BLUE = 2.
  - Function for the packed row field offset.
- Sub-module led_pattern_level_gen: combinational, plus an optional gamma register. Takes mode, column, physical row, scan_pos and pulse level; returns the COLOUR_DEPTH-bit level. Instantiated per column via generate, top and bottom halves.

Test Plan (NUM_ROW_PIXELS=32, NUM_COL_PIXELS=64, COLOUR_DEPTH=4, SIMULATION=1, macro undefined):
- Reset then ready=1, MODE_SOLID, colour=3'b101 -> valid on 2nd edge. Address 0..15 repeats with plane 0..3; every row has red and blue all ones, green 0. frame_last_out high once per 64 transfers.
- MODE_GRADIENT, colour=3'b010, ready toggling every cycle -> data held while ready=0. Plane 2, column 17 (level 4): green bit 1. Plane 0, column 17: green bit 0.
- MODE_SCAN_H, colour=3'b111 -> frame N lights only column N mod 64 on every plane. Column 63 wraps to column 0.
- MODE_PULSE, colour=3'b001 -> red level sequence per frame 0,1,...,15,14,...,0,1. Rows are uniform.
- Mode change MODE_SOLID -> MODE_SCAN_V mid-frame (address 9, plane 2) -> valid low 1 cycle, next row address 0 plane 0, top row 0 lit.
- reset_in pulsed during valid with ready=0 -> outputs 0 immediately; the sequence restarts at address 0.

Source files
------------

// File: rtl/led_display_pattern_gen_bcm_pkg.sv
// Shared types and helpers for the BCM LED pattern generator.
// Optional gamma stage is enabled with the LED_PATTERN_GAMMA_EN macro.
package led_display_pattern_gen_bcm_pkg;

  typedef enum logic [3:0] {
    MODE_OFF      = 4'd0,
    MODE_SOLID    = 4'd1,
    MODE_SCAN_H   = 4'd2,
    MODE_SCAN_V   = 4'd3,
    MODE_PULSE    = 4'd4,
    MODE_GRADIENT = 4'd5
  } mode_e;

  localparam int RED    = 0;
  localparam int GREEN  = 1;
  localparam int BLUE   = 2;
  localparam int NUM_CH = 3;

  // S_PRIME only exists to fill the gamma register after a restart.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_LOAD  = 2'd2,
    S_VALID = 2'd3
  } state_e;

  // Bit offset of a colour field inside the packed row: half 0 = top, 1 = bottom.
  function automatic int row_field_off(input int half, input int ch, input int ncol);
    return (half * NUM_CH + ch) * ncol;
  endfunction

endpackage

// File: rtl/led_display_pattern_gen_bcm_level_gen.sv
// Per-pixel intensity level for the selected pattern mode.
// With LED_PATTERN_GAMMA_EN defined the level is gamma-2 corrected and registered.
module led_pattern_level_gen
  import led_display_pattern_gen_bcm_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int COLOUR_DEPTH   = 4,
  localparam int CW = $clog2(NUM_COL_PIXELS),
  localparam int RW = $clog2(NUM_ROW_PIXELS),
  localparam int SW = (NUM_COL_PIXELS > NUM_ROW_PIXELS) ? CW : RW
) (
`ifdef LED_PATTERN_GAMMA_EN
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    en_in,
`endif
  input  logic [3:0]              mode_in,
  input  logic [CW-1:0]           col_in,
  input  logic [RW-1:0]           row_in,
  input  logic [SW-1:0]           scan_pos_in,
  input  logic [COLOUR_DEPTH-1:0] pulse_in,
  output logic [COLOUR_DEPTH-1:0] level_out
);

  logic [COLOUR_DEPTH-1:0] lin;

  // Linear level from mode; unknown modes are dark.
  always_comb begin
    lin = '0;
    case (mode_in)
      MODE_SOLID:    lin = '1;
      MODE_SCAN_H:   lin = (SW'(col_in) == scan_pos_in) ? '1 : '0;
      MODE_SCAN_V:   lin = (SW'(row_in) == scan_pos_in) ? '1 : '0;
      MODE_PULSE:    lin = pulse_in;
      MODE_GRADIENT: lin = col_in[CW-1 -: COLOUR_DEPTH];
      default:       lin = '0;
    endcase
  end

`ifdef LED_PATTERN_GAMMA_EN
  logic [2*COLOUR_DEPTH-1:0] sq;
  logic [COLOUR_DEPTH-1:0]   gam;
  logic [COLOUR_DEPTH-1:0]   level_q;

  // Gamma-2; full scale is pinned so MAX stays MAX after truncation.
  always_comb begin
    sq  = {{COLOUR_DEPTH{1'b0}}, lin} * {{COLOUR_DEPTH{1'b0}}, lin};
    gam = (lin == '1) ? '1 : sq[2*COLOUR_DEPTH-1:COLOUR_DEPTH];
  end

  // Pipeline register holding the corrected level one row ahead of the output.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in)   level_q <= '0;
    else if (en_in) level_q <= gam;
  end

  assign level_out = level_q;
`else
  assign level_out = lin;
`endif

endmodule

// File: rtl/led_display_pattern_gen_bcm.sv
// BCM bit-plane pattern generator for HUB75-style panels.
// Streams one dual-row bit-plane per valid/ready transfer; a look-ahead row
// register keeps valid high back-to-back. Optional macro: LED_PATTERN_GAMMA_EN.
module led_display_pattern_gen_bcm
  import led_display_pattern_gen_bcm_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int COLOUR_DEPTH   = 4,
  parameter int SCAN_DIV       = 4,
  parameter int PULSE_DIV      = 2,
  parameter int SIMULATION     = 0,
  localparam int NSR = NUM_ROW_PIXELS / 2,
  localparam int AW  = (NSR > 1) ? $clog2(NSR) : 1,
  localparam int PW  = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1
) (
  input  logic                        clk_in,
  input  logic                        reset_in,
  input  logic [2:0]                  colour_in,
  input  logic [3:0]                  mode_in,
  output logic [6*NUM_COL_PIXELS-1:0] row_out,
  output logic                        row_valid_out,
  input  logic                        row_ready_in,
  output logic [AW-1:0]               row_address_out,
  output logic [PW-1:0]               plane_out,
  output logic                        frame_last_out
);

  localparam int CW          = $clog2(NUM_COL_PIXELS);
  localparam int RW          = $clog2(NUM_ROW_PIXELS);
  localparam int SW          = (NUM_COL_PIXELS > NUM_ROW_PIXELS) ? CW : RW;
  localparam int SCAN_DIV_E  = (SIMULATION != 0) ? 1 : SCAN_DIV;
  localparam int PULSE_DIV_E = (SIMULATION != 0) ? 1 : PULSE_DIV;
`ifdef LED_PATTERN_GAMMA_EN
  localparam state_e FILL_S = S_PRIME;
`else
  localparam state_e FILL_S = S_LOAD;
`endif

  // Everything that determines the content of one row.
  typedef struct packed {
    logic [AW-1:0]           addr;
    logic [PW-1:0]           plane;
    logic [15:0]             scan_cnt;
    logic [15:0]             pulse_cnt;
    logic [SW-1:0]           scan_pos;
    logic [COLOUR_DEPTH-1:0] pulse;
    logic                    pulse_down;
  } pos_t;

  // Step to the following row; the frame-rate effects fire on the last row.
  function automatic pos_t advance(input pos_t p, input logic scan_v);
    pos_t n;
    n = p;
    if (p.addr != AW'(NSR-1)) begin
      n.addr = p.addr + 1'b1;
    end else begin
      n.addr = '0;
      if (p.plane != PW'(COLOUR_DEPTH-1)) begin
        n.plane = p.plane + 1'b1;
      end else begin
        n.plane = '0;
        if (p.scan_cnt == 16'(SCAN_DIV_E-1)) begin
          n.scan_cnt = '0;
          if (p.scan_pos == (scan_v ? SW'(NUM_ROW_PIXELS-1) : SW'(NUM_COL_PIXELS-1)))
            n.scan_pos = '0;
          else
            n.scan_pos = p.scan_pos + 1'b1;
        end else begin
          n.scan_cnt = p.scan_cnt + 16'd1;
        end
        if (p.pulse_cnt == 16'(PULSE_DIV_E-1)) begin
          n.pulse_cnt = '0;
          if (!p.pulse_down) begin
            n.pulse = p.pulse + 1'b1;
            if (n.pulse == '1) n.pulse_down = 1'b1;
          end else begin
            n.pulse = p.pulse - 1'b1;
            if (n.pulse == '0) n.pulse_down = 1'b0;
          end
        end else begin
          n.pulse_cnt = p.pulse_cnt + 16'd1;
        end
      end
    end
    return n;
  endfunction

  state_e                  state_q, state_d;
  pos_t                    pos_q, pos_nxt, lvl_pos, row_pos;
  logic [3:0]              mode_q;
  logic [2:0]              colour_q;
  logic                    change, xfer, ld, step, lvl_en;
  logic [6*NUM_COL_PIXELS-1:0] row_d, row_q;
  logic [AW-1:0]           addr_q;
  logic [PW-1:0]           plane_q;
  logic                    last_q;
  logic [1:0][NUM_COL_PIXELS-1:0][COLOUR_DEPTH-1:0] lvl;

  assign change = (mode_in != mode_q) || (colour_in != colour_q);
  assign xfer   = row_valid_out && row_ready_in;
  assign ld     = (state_q == S_LOAD) || xfer;

  // Look-ahead position and which position feeds the level generators / row.
  always_comb begin
    pos_nxt = advance(pos_q, mode_in == MODE_SCAN_V);
`ifdef LED_PATTERN_GAMMA_EN
    lvl_pos = (state_q == S_PRIME) ? pos_q : pos_nxt;
    row_pos = pos_q;
    step    = ld;
    lvl_en  = (state_q == S_PRIME) || ld;
`else
    lvl_pos = (state_q == S_VALID) ? pos_nxt : pos_q;
    row_pos = lvl_pos;
    step    = xfer;
    lvl_en  = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: any mode/colour change forces a reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = FILL_S;
      S_PRIME: state_d = change ? S_PRIME : S_LOAD;
      S_LOAD:  state_d = change ? FILL_S : S_VALID;
      S_VALID: state_d = change ? FILL_S : S_VALID;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    row_valid_out = (state_q == S_VALID);
  end

  // Sequence counters, change detector and the output row register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pos_q    <= '0;
      mode_q   <= '0;
      colour_q <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      plane_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      mode_q   <= mode_in;
      colour_q <= colour_in;
      if (ld) begin
        row_q   <= row_d;
        addr_q  <= row_pos.addr;
        plane_q <= row_pos.plane;
        last_q  <= (row_pos.addr == AW'(NSR-1)) && (row_pos.plane == PW'(COLOUR_DEPTH-1));
      end
      if (change)    pos_q <= '0;
      else if (step) pos_q <= pos_nxt;
    end
  end

  // Per-pixel level generators for the top and bottom halves.
  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar c = 0; c < NUM_COL_PIXELS; c++) begin : g_col
      led_pattern_level_gen #(
        .SYS_CLK_FREQ  (SYS_CLK_FREQ),
        .NUM_ROW_PIXELS(NUM_ROW_PIXELS),
        .NUM_COL_PIXELS(NUM_COL_PIXELS),
        .COLOUR_DEPTH  (COLOUR_DEPTH)
      ) u_lvl (
`ifdef LED_PATTERN_GAMMA_EN
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .en_in      (lvl_en),
`endif
        .mode_in    (mode_in),
        .col_in     (CW'(c)),
        .row_in     (RW'(lvl_pos.addr) + RW'(h * NSR)),
        .scan_pos_in(lvl_pos.scan_pos),
        .pulse_in   (lvl_pos.pulse),
        .level_out  (lvl[h][c])
      );
      for (genvar ch = RED; ch <= BLUE; ch++) begin : g_ch
        localparam int OFF = row_field_off(h, ch, NUM_COL_PIXELS);
        assign row_d[OFF + c] = colour_in[ch] & lvl[h][c][row_pos.plane];
      end
    end
  end

  assign row_out         = row_q;
  assign row_address_out = addr_q;
  assign plane_out       = plane_q;
  assign frame_last_out  = last_q;

endmodule

// File: tb/tb_led_display_pattern_gen_bcm.sv
// Self-checking bench for led_display_pattern_gen_bcm (linear build, SIMULATION=1).
module tb_led_display_pattern_gen_bcm;

  localparam int NR   = 32;
  localparam int NC   = 64;
  localparam int CD   = 4;
  localparam int NSR  = NR / 2;
  localparam int MAXL = (1 << CD) - 1;
  localparam int RPF  = NSR * CD;   // transfers per frame

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [2:0]      colour_in;
  logic [3:0]      mode_in;
  logic [6*NC-1:0] row_out;
  logic            row_valid_out;
  logic            row_ready_in;
  logic [3:0]      row_address_out;
  logic [1:0]      plane_out;
  logic            frame_last_out;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          n_xfer = 0;
  int          cur_mode = 0;
  logic [2:0]  cur_colour = 3'b000;

  always #5 clk_in = ~clk_in;

  led_display_pattern_gen_bcm #(
    .NUM_ROW_PIXELS(NR), .NUM_COL_PIXELS(NC), .COLOUR_DEPTH(CD), .SIMULATION(1)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in), .colour_in(colour_in), .mode_in(mode_in),
    .row_out(row_out), .row_valid_out(row_valid_out), .row_ready_in(row_ready_in),
    .row_address_out(row_address_out), .plane_out(plane_out), .frame_last_out(frame_last_out)
  );

  // Reference level straight from the pattern definitions; f = frame index since restart.
  function automatic logic [CD-1:0] m_level(input int mode, input int col, input int prow, input int f);
    int t;
    case (mode)
      1: return CD'(MAXL);
      2: return (col == f % NC) ? CD'(MAXL) : CD'(0);
      3: return (prow == f % NR) ? CD'(MAXL) : CD'(0);
      4: begin
        t = f % (2 * MAXL);
        return (t <= MAXL) ? CD'(t) : CD'(2 * MAXL - t);
      end
      5: return CD'(col * (1 << CD) / NC);
      default: return CD'(0);
    endcase
  endfunction

  // Reference row for the n-th transfer since restart.
  function automatic logic [6*NC-1:0] m_row(input int mode, input logic [2:0] colour, input int n);
    logic [6*NC-1:0] r;
    logic [CD-1:0]   lv;
    int addr, plane, f;
    r = '0;
    addr = n % NSR; plane = (n / NSR) % CD; f = n / RPF;
    for (int h = 0; h < 2; h++)
      for (int c = 0; c < NC; c++) begin
        lv = m_level(mode, c, addr + h * NSR, f);
        for (int ch = 0; ch < 3; ch++) r[(h * 3 + ch) * NC + c] = colour[ch] & lv[plane];
      end
    return r;
  endfunction

  // Stimulus: switch mode/colour and wait through the forced reload.
  task automatic restart(input int m, input logic [2:0] c);
    if (m == cur_mode && c == cur_colour) c = c ^ 3'b001;
    mode_in = 4'(m); colour_in = c; cur_mode = m; cur_colour = c;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    n_xfer = 0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1; row_ready_in = 1'b0;
    mode_in = 4'd1; colour_in = 3'b101; cur_mode = 1; cur_colour = 3'b101;
    repeat (3) begin
      @(posedge clk_in); #1;
      chk_cnt++;
      if (row_valid_out !== 1'b0 || row_out !== '0 || row_address_out !== 4'd0 ||
          plane_out !== 2'd0 || frame_last_out !== 1'b0)
        $display("FAIL reset_state: valid=%b row=%h addr=%0d plane=%0d last=%b, all required 0",
                 row_valid_out, row_out, row_address_out, plane_out, frame_last_out);
      else pass_cnt++;
    end
    @(negedge clk_in); reset_in = 1'b0; row_ready_in = 1'b1;
    @(posedge clk_in); #1;
    chk_cnt++;
    if (row_valid_out !== 1'b0) $display("FAIL first_edge_valid: got %b want 0", row_valid_out);
    else pass_cnt++;
    @(posedge clk_in); #1;
    n_xfer = 0;
    chk_cnt++;
    if (row_valid_out !== 1'b1 || row_address_out !== 4'd0 || plane_out !== 2'd0)
      $display("FAIL second_edge_valid: valid=%b addr=%0d plane=%0d want 1/0/0",
               row_valid_out, row_address_out, plane_out);
    else pass_cnt++;
  endtask

  task automatic test_solid();
    int last_seen = 0, last_exp = 0;
    for (int i = 0; i < 140; i++) begin
      row_ready_in = 1'b1;
      chk_cnt++;
      if (row_valid_out !== 1'b1 || row_out !== m_row(cur_mode, cur_colour, n_xfer) ||
          row_address_out !== 4'(n_xfer % NSR) || plane_out !== 2'((n_xfer / NSR) % CD) ||
          frame_last_out !== ((n_xfer % RPF) == RPF - 1))
        $display("FAIL solid_row n=%0d: valid=%b addr=%0d plane=%0d last=%b row=%h want %h",
                 n_xfer, row_valid_out, row_address_out, plane_out, frame_last_out,
                 row_out, m_row(cur_mode, cur_colour, n_xfer));
      else pass_cnt++;
      if (row_valid_out && row_ready_in) begin
        if (frame_last_out) last_seen++;
        if ((n_xfer % RPF) == RPF - 1) last_exp++;
        n_xfer++;
      end
      @(posedge clk_in); #1;
    end
    chk_cnt++;
    if (last_seen !== last_exp) $display("FAIL frame_last_count: got %0d want %0d", last_seen, last_exp);
    else pass_cnt++;
  endtask

  task automatic test_gradient();
    restart(5, 3'b010);
    for (int i = 0; i < 200; i++) begin
      row_ready_in = i[0];
      chk_cnt++;
      if (row_valid_out !== 1'b1 || row_out !== m_row(cur_mode, cur_colour, n_xfer) ||
          row_address_out !== 4'(n_xfer % NSR) || plane_out !== 2'((n_xfer / NSR) % CD))
        $display("FAIL gradient_row n=%0d: valid=%b addr=%0d plane=%0d row=%h want %h",
                 n_xfer, row_valid_out, row_address_out, plane_out, row_out,
                 m_row(cur_mode, cur_colour, n_xfer));
      else pass_cnt++;
      if (n_xfer == 0 || n_xfer == 2 * NSR) begin
        chk_cnt++;
        if (row_out[NC + 17] !== (n_xfer == 2 * NSR))
          $display("FAIL gradient_col17 plane=%0d: got %b want %b", plane_out, row_out[NC + 17],
                   n_xfer == 2 * NSR);
        else pass_cnt++;
      end
      if (row_valid_out && row_ready_in) n_xfer++;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_scan_h();
    restart(2, 3'b111);
    while (n_xfer < 65 * RPF + 3) begin
      row_ready_in = ($urandom_range(0, 3) != 0);
      chk_cnt++;
      if (row_valid_out !== 1'b1 || row_out !== m_row(cur_mode, cur_colour, n_xfer) ||
          row_address_out !== 4'(n_xfer % NSR) || plane_out !== 2'((n_xfer / NSR) % CD))
        $display("FAIL scan_h_row n=%0d: valid=%b addr=%0d plane=%0d row=%h want %h",
                 n_xfer, row_valid_out, row_address_out, plane_out, row_out,
                 m_row(cur_mode, cur_colour, n_xfer));
      else pass_cnt++;
      if (row_valid_out && row_ready_in) n_xfer++;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_pulse();
    restart(4, 3'b001);
    for (int i = 0; i < 33 * RPF; i++) begin
      row_ready_in = 1'b1;
      chk_cnt++;
      if (row_valid_out !== 1'b1 || row_out !== m_row(cur_mode, cur_colour, n_xfer) ||
          row_address_out !== 4'(n_xfer % NSR) || plane_out !== 2'((n_xfer / NSR) % CD))
        $display("FAIL pulse_row n=%0d: valid=%b addr=%0d plane=%0d row=%h want %h",
                 n_xfer, row_valid_out, row_address_out, plane_out, row_out,
                 m_row(cur_mode, cur_colour, n_xfer));
      else pass_cnt++;
      if (row_valid_out && row_ready_in) n_xfer++;
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_mode_change();
    logic [2:0]      c;
    logic [3*NC-1:0] exp_top;
    c = 3'($urandom_range(1, 7));
    restart(1, c);
    for (int i = 0; i < 2 * NSR + 9; i++) begin
      row_ready_in = 1'b1;
      if (row_valid_out && row_ready_in) n_xfer++;
      @(posedge clk_in); #1;
    end
    chk_cnt++;
    if (row_valid_out !== 1'b1 || row_address_out !== 4'd9 || plane_out !== 2'd2)
      $display("FAIL change_point: valid=%b addr=%0d plane=%0d want 1/9/2",
               row_valid_out, row_address_out, plane_out);
    else pass_cnt++;
    mode_in = 4'd3; cur_mode = 3;
    @(posedge clk_in); #1;
    chk_cnt++;
    if (row_valid_out !== 1'b0) $display("FAIL change_valid_drop: got %b want 0", row_valid_out);
    else pass_cnt++;
    @(posedge clk_in); #1;
    exp_top = {{NC{cur_colour[2]}}, {NC{cur_colour[1]}}, {NC{cur_colour[0]}}};
    chk_cnt++;
    if (row_valid_out !== 1'b1 || row_address_out !== 4'd0 || plane_out !== 2'd0 ||
        row_out[3*NC-1:0] !== exp_top || row_out[6*NC-1:3*NC] !== '0)
      $display("FAIL change_restart: valid=%b addr=%0d plane=%0d row=%h want top=%h bottom=0",
               row_valid_out, row_address_out, plane_out, row_out, exp_top);
    else pass_cnt++;
  endtask

  task automatic test_random();
    n_xfer = 0;
    for (int k = 0; k < 6; k++) begin
      row_ready_in = 1'b0;
      mode_in = 4'($urandom_range(0, 15));
      colour_in = 3'($urandom_range(0, 7));
      if (mode_in == 4'(cur_mode) && colour_in == cur_colour) colour_in = colour_in ^ 3'b100;
      cur_mode = int'(mode_in); cur_colour = colour_in;
      @(posedge clk_in); #1;
      chk_cnt++;
      if (row_valid_out !== 1'b0) $display("FAIL random_drop k=%0d: valid=%b want 0", k, row_valid_out);
      else pass_cnt++;
      @(posedge clk_in); #1;
      n_xfer = 0;
      for (int i = 0; i < 250; i++) begin
        row_ready_in = $urandom_range(0, 1);
        chk_cnt++;
        if (row_valid_out !== 1'b1 || row_out !== m_row(cur_mode, cur_colour, n_xfer) ||
            row_address_out !== 4'(n_xfer % NSR) || plane_out !== 2'((n_xfer / NSR) % CD))
          $display("FAIL random_row mode=%0d n=%0d: valid=%b addr=%0d plane=%0d row=%h want %h",
                   cur_mode, n_xfer, row_valid_out, row_address_out, plane_out, row_out,
                   m_row(cur_mode, cur_colour, n_xfer));
        else pass_cnt++;
        if (row_valid_out && row_ready_in) n_xfer++;
        @(posedge clk_in); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    row_ready_in = 1'b0;
    @(posedge clk_in); #1;
    reset_in = 1'b1;
    #1;
    chk_cnt++;
    if (row_valid_out !== 1'b0 || row_out !== '0 || row_address_out !== 4'd0 ||
        plane_out !== 2'd0 || frame_last_out !== 1'b0)
      $display("FAIL reset_mid_clear: valid=%b addr=%0d plane=%0d last=%b row=%h want all 0",
               row_valid_out, row_address_out, plane_out, frame_last_out, row_out);
    else pass_cnt++;
    #4 reset_in = 1'b0;
    @(posedge clk_in); #1;
    chk_cnt++;
    if (row_valid_out !== 1'b0) $display("FAIL reset_mid_edge1: valid=%b want 0", row_valid_out);
    else pass_cnt++;
    @(posedge clk_in); #1;
    chk_cnt++;
    if (row_valid_out !== 1'b1 || row_address_out !== 4'd0 || plane_out !== 2'd0 ||
        row_out !== m_row(cur_mode, cur_colour, 0))
      $display("FAIL reset_mid_restart: valid=%b addr=%0d plane=%0d row=%h want %h",
               row_valid_out, row_address_out, plane_out, row_out, m_row(cur_mode, cur_colour, 0));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_solid();
    test_gradient();
    test_scan_h();
    test_pulse();
    test_mode_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
